// File: rtl/parking_slot_manager_pkg.sv
// Shared constants for the parking slot manager: parameter defaults and FSM encodings.
package parking_slot_manager_pkg;

  localparam int unsigned NUM_SLOTS_DEF = 8;
  localparam int unsigned VNO_W_DEF     = 32;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SCAN_ENTRY = 2'd1;
  localparam logic [1:0] ST_SCAN_EXIT  = 2'd2;
  localparam logic [1:0] ST_RESP       = 2'd3;

endpackage

// File: rtl/parking_slot_manager_slot_table.sv
// Slot storage: NUM_SLOTS x (valid, vehicle number) with one indexed read, a set port and a clear port.
module slot_table
  import parking_slot_manager_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter  int unsigned VNO_W     = VNO_W_DEF,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [SLOT_W-1:0] i_rd_idx,
  output logic              o_rd_valid,
  output logic [VNO_W-1:0]  o_rd_vno,
  input  logic              i_set_en,
  input  logic [SLOT_W-1:0] i_set_idx,
  input  logic [VNO_W-1:0]  i_set_vno,
  input  logic              i_clr_en,
  input  logic [SLOT_W-1:0] i_clr_idx
);

  logic             r_valid [NUM_SLOTS];
  logic [VNO_W-1:0] r_vno   [NUM_SLOTS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_valid[i] <= 1'b0;
        r_vno[i]   <= '0;
      end
    end else begin
      if (i_set_en) begin
        r_valid[i_set_idx] <= 1'b1;
        r_vno[i_set_idx]   <= i_set_vno;
      end
      if (i_clr_en) begin
        r_valid[i_clr_idx] <= 1'b0;
      end
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_vno   = r_vno[i_rd_idx];

endmodule

// File: rtl/parking_slot_manager.sv
// Slot allocator behind car_parking: edge-detects entry/exit events, scans the slot table serially,
// and answers each event with a one-cycle ack/nack pulse while tracking occupancy.
module parking_slot_manager
  import parking_slot_manager_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter  int unsigned VNO_W     = VNO_W_DEF,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              car_parked,
  input  logic [VNO_W-1:0]  vehicle_no,
  input  logic              exit_req,
  input  logic [VNO_W-1:0]  exit_vno,
  output logic              entry_ack,
  output logic              entry_nack,
  output logic              dup_err,
  output logic              exit_ack,
  output logic              exit_nack,
  output logic [SLOT_W-1:0] slot_id,
  output logic [SLOT_W:0]   occ_count,
  output logic              full,
  output logic              empty,
  output logic              overrun
);

  localparam logic [SLOT_W:0]   OCC_MAX  = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] IDX_LAST = SLOT_W'(NUM_SLOTS - 1);

  logic              r_cp_d;
  logic              r_ex_d;
  logic              r_ent_pend;
  logic              r_ex_pend;
  logic [VNO_W-1:0]  r_ent_vno;
  logic [VNO_W-1:0]  r_ex_vno;
  logic [1:0]        r_state;
  logic              r_is_entry;
  logic [SLOT_W-1:0] r_idx;
  logic [SLOT_W-1:0] r_sel;
  logic              r_found;
  logic              r_dup;

  logic              w_ent_edge;
  logic              w_ex_edge;
  logic              w_ent_clr;
  logic              w_ex_clr;
  logic              w_rd_valid;
  logic [VNO_W-1:0]  w_rd_vno;
  logic              w_match;
  logic              w_set;
  logic              w_clr;

  assign w_ent_edge = car_parked & ~r_cp_d;
  assign w_ex_edge  = exit_req & ~r_ex_d;
  assign w_ent_clr  = (r_state == ST_RESP) &  r_is_entry;
  assign w_ex_clr   = (r_state == ST_RESP) & ~r_is_entry;
  assign w_match    = w_rd_valid &&
                      (w_rd_vno == ((r_state == ST_SCAN_ENTRY) ? r_ent_vno : r_ex_vno));
  assign w_set      = w_ent_clr & ~r_dup & r_found;
  assign w_clr      = w_ex_clr & r_found;

  assign full  = (occ_count == OCC_MAX);
  assign empty = (occ_count == '0);

  slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .VNO_W     (VNO_W)
  ) u_slot_table (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rd_idx   (r_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_vno   (w_rd_vno),
    .i_set_en   (w_set),
    .i_set_idx  (r_sel),
    .i_set_vno  (r_ent_vno),
    .i_clr_en   (w_clr),
    .i_clr_idx  (r_sel)
  );

  // Capture beats clear: an edge landing in the RESP cycle refills the latch being freed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cp_d     <= 1'b0;
      r_ex_d     <= 1'b0;
      r_ent_pend <= 1'b0;
      r_ex_pend  <= 1'b0;
      r_ent_vno  <= '0;
      r_ex_vno   <= '0;
      overrun    <= 1'b0;
    end else begin
      r_cp_d  <= car_parked;
      r_ex_d  <= exit_req;
      overrun <= (w_ent_edge & r_ent_pend & ~w_ent_clr) |
                 (w_ex_edge  & r_ex_pend  & ~w_ex_clr);
      if (w_ent_edge && !(r_ent_pend && !w_ent_clr)) begin
        r_ent_pend <= 1'b1;
        r_ent_vno  <= vehicle_no;
      end else if (w_ent_clr) begin
        r_ent_pend <= 1'b0;
      end
      if (w_ex_edge && !(r_ex_pend && !w_ex_clr)) begin
        r_ex_pend <= 1'b1;
        r_ex_vno  <= exit_vno;
      end else if (w_ex_clr) begin
        r_ex_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_is_entry <= 1'b0;
      r_idx      <= '0;
      r_sel      <= '0;
      r_found    <= 1'b0;
      r_dup      <= 1'b0;
      entry_ack  <= 1'b0;
      entry_nack <= 1'b0;
      dup_err    <= 1'b0;
      exit_ack   <= 1'b0;
      exit_nack  <= 1'b0;
      slot_id    <= '0;
      occ_count  <= '0;
    end else begin
      entry_ack  <= 1'b0;
      entry_nack <= 1'b0;
      dup_err    <= 1'b0;
      exit_ack   <= 1'b0;
      exit_nack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idx   <= '0;
          r_found <= 1'b0;
          r_dup   <= 1'b0;
          if (r_ent_pend) begin
            r_state    <= ST_SCAN_ENTRY;
            r_is_entry <= 1'b1;
          end else if (r_ex_pend) begin
            r_state    <= ST_SCAN_EXIT;
            r_is_entry <= 1'b0;
          end
        end
        ST_SCAN_ENTRY: begin
          if (!w_rd_valid && !r_found) begin
            r_found <= 1'b1;
            r_sel   <= r_idx;
          end
          if (w_match) r_dup <= 1'b1;
          r_idx <= r_idx + SLOT_W'(1);
          if (r_idx == IDX_LAST) r_state <= ST_RESP;
        end
        ST_SCAN_EXIT: begin
          if (w_match && !r_found) begin
            r_found <= 1'b1;
            r_sel   <= r_idx;
          end
          r_idx <= r_idx + SLOT_W'(1);
          if (r_idx == IDX_LAST) r_state <= ST_RESP;
        end
        default: begin
          r_state <= ST_IDLE;
          if (r_is_entry) begin
            if (r_dup) begin
              entry_nack <= 1'b1;
              dup_err    <= 1'b1;
            end else if (!r_found || occ_count == OCC_MAX) begin
              entry_nack <= 1'b1;
            end else begin
              entry_ack <= 1'b1;
              slot_id   <= r_sel;
              occ_count <= occ_count + (SLOT_W+1)'(1);
            end
          end else begin
            if (r_found && occ_count != '0) begin
              exit_ack  <= 1'b1;
              slot_id   <= r_sel;
              occ_count <= occ_count - (SLOT_W+1)'(1);
            end else begin
              exit_nack <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed bench for parking_slot_manager: vector table of single events plus multi-cycle corner sequences.
module tb_parking_slot_manager;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        car_parked = 1'b0;
  logic [31:0] vehicle_no = '0;
  logic        exit_req = 1'b0;
  logic [31:0] exit_vno = '0;
  logic        entry_ack, entry_nack, dup_err, exit_ack, exit_nack;
  logic [2:0]  slot_id;
  logic [3:0]  occ_count;
  logic        full, empty, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // captured outputs at the response cycle
  logic       c_eack, c_enack, c_dup, c_xack, c_xnack;
  logic [2:0] c_slot;
  logic [3:0] c_occ;
  logic       c_full, c_empty;

  typedef struct {
    bit          is_exit;
    logic [31:0] vno;
    int          kind;   // 0 entry_ack, 1 entry_nack, 2 entry_nack+dup, 3 exit_ack, 4 exit_nack
    logic [2:0]  slot;
    logic [3:0]  occ;
  } vec_t;

  vec_t vecs[16];

  parking_slot_manager #(
    .NUM_SLOTS (8),
    .VNO_W     (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .car_parked (car_parked),
    .vehicle_no (vehicle_no),
    .exit_req   (exit_req),
    .exit_vno   (exit_vno),
    .entry_ack  (entry_ack),
    .entry_nack (entry_nack),
    .dup_err    (dup_err),
    .exit_ack   (exit_ack),
    .exit_nack  (exit_nack),
    .slot_id    (slot_id),
    .occ_count  (occ_count),
    .full       (full),
    .empty      (empty),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit is_exit, logic [31:0] vno, int kind, logic [2:0] slot, logic [3:0] occ);
    vec_t v;
    v.is_exit = is_exit;
    v.vno     = vno;
    v.kind    = kind;
    v.slot    = slot;
    v.occ     = occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_event(input bit is_exit, input logic [31:0] v, output int lat);
    @(negedge clk);
    if (is_exit) begin
      exit_req = 1'b1;
      exit_vno = v;
    end else begin
      car_parked = 1'b1;
      vehicle_no = v;
    end
    @(negedge clk);
    car_parked = 1'b0;
    exit_req   = 1'b0;
    lat = -1;
    {c_eack, c_enack, c_dup, c_xack, c_xnack, c_full, c_empty} = '0;
    c_slot = '0;
    c_occ  = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (entry_ack | entry_nack | exit_ack | exit_nack) begin
        lat     = i;
        c_eack  = entry_ack;
        c_enack = entry_nack;
        c_dup   = dup_err;
        c_xack  = exit_ack;
        c_xnack = exit_nack;
        c_slot  = slot_id;
        c_occ   = occ_count;
        c_full  = full;
        c_empty = empty;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int e_at, e2_at, x_at, o_at, n_ent;
    logic ea, e2nack, e2dup, xa, any;
    logic [2:0] es, e2s, xs;
    logic [3:0] eo, xo;

    vecs[0]  = mk(0, 32'd1104, 0, 3'd0, 4'd1);
    vecs[1]  = mk(0, 32'd1104, 2, 3'd0, 4'd1);
    vecs[2]  = mk(0, 32'd2501, 0, 3'd1, 4'd2);
    vecs[3]  = mk(0, 32'd3001, 0, 3'd2, 4'd3);
    vecs[4]  = mk(0, 32'd3002, 0, 3'd3, 4'd4);
    vecs[5]  = mk(0, 32'd3003, 0, 3'd4, 4'd5);
    vecs[6]  = mk(0, 32'd3004, 0, 3'd5, 4'd6);
    vecs[7]  = mk(0, 32'd3005, 0, 3'd6, 4'd7);
    vecs[8]  = mk(0, 32'd3006, 0, 3'd7, 4'd8);
    vecs[9]  = mk(0, 32'd5601, 1, 3'd7, 4'd8);
    vecs[10] = mk(1, 32'd2501, 3, 3'd1, 4'd7);
    vecs[11] = mk(0, 32'd7777, 0, 3'd1, 4'd8);
    vecs[12] = mk(1, 32'd9999, 4, 3'd1, 4'd8);
    vecs[13] = mk(1, 32'd3001, 3, 3'd2, 4'd7);
    vecs[14] = mk(0, 32'd0,    0, 3'd2, 4'd8);
    vecs[15] = mk(1, 32'd0,    3, 3'd2, 4'd7);

    repeat (2) @(negedge clk);
    chk("rst_pulses", {entry_ack, entry_nack, dup_err, exit_ack, exit_nack, overrun}, 0);
    chk("rst_slot", slot_id, 0);
    chk("rst_occ", occ_count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    reset = 1'b0;

    foreach (vecs[k]) begin
      do_event(vecs[k].is_exit, vecs[k].vno, lat);
      chk($sformatf("v%0d_lat", k), lat, 10);
      chk($sformatf("v%0d_eack", k), c_eack, vecs[k].kind == 0);
      chk($sformatf("v%0d_enack", k), c_enack, vecs[k].kind == 1 || vecs[k].kind == 2);
      chk($sformatf("v%0d_dup", k), c_dup, vecs[k].kind == 2);
      chk($sformatf("v%0d_xack", k), c_xack, vecs[k].kind == 3);
      chk($sformatf("v%0d_xnack", k), c_xnack, vecs[k].kind == 4);
      chk($sformatf("v%0d_slot", k), c_slot, vecs[k].slot);
      chk($sformatf("v%0d_occ", k), c_occ, vecs[k].occ);
      chk($sformatf("v%0d_full", k), c_full, vecs[k].occ == 4'd8);
      chk($sformatf("v%0d_empty", k), c_empty, vecs[k].occ == 4'd0);
    end

    // Simultaneous entry+exit, plus a second entry edge while entry is still pending.
    @(negedge clk);
    car_parked = 1'b1; exit_req = 1'b1; vehicle_no = 32'd4444; exit_vno = 32'd1104;
    @(negedge clk);
    car_parked = 1'b0; exit_req = 1'b0;
    e_at = -1; x_at = -1; o_at = -1; n_ent = 0;
    ea = 0; xa = 0; es = '0; xs = '0; eo = '0; xo = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (entry_ack | entry_nack) begin
        n_ent++;
        if (e_at < 0) begin e_at = i; ea = entry_ack; es = slot_id; eo = occ_count; end
      end
      if ((exit_ack | exit_nack) && x_at < 0) begin x_at = i; xa = exit_ack; xs = slot_id; xo = occ_count; end
      if (overrun && o_at < 0) o_at = i;
      if (i == 1) begin car_parked = 1'b1; vehicle_no = 32'd5555; end
      if (i == 2) car_parked = 1'b0;
    end
    chk("sim_ovr_at", o_at, 2);
    chk("sim_entry_at", e_at, 10);
    chk("sim_entry_ack", ea, 1);
    chk("sim_entry_slot", es, 2);
    chk("sim_entry_occ", eo, 8);
    chk("sim_entry_count", n_ent, 1);
    chk("sim_exit_at", x_at, 20);
    chk("sim_exit_ack", xa, 1);
    chk("sim_exit_slot", xs, 0);
    chk("sim_exit_occ", xo, 7);

    // New entry edge in the very cycle RESP frees the entry latch: captured, no overrun.
    @(negedge clk);
    car_parked = 1'b1; vehicle_no = 32'd6666;
    @(negedge clk);
    car_parked = 1'b0;
    e_at = -1; e2_at = -1; o_at = -1;
    ea = 0; e2nack = 0; e2dup = 0; es = '0; e2s = '0; eo = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (entry_ack | entry_nack) begin
        if (e_at < 0) begin e_at = i; ea = entry_ack; es = slot_id; eo = occ_count; end
        else if (e2_at < 0) begin e2_at = i; e2nack = entry_nack; e2dup = dup_err; e2s = slot_id; end
      end
      if (overrun && o_at < 0) o_at = i;
      if (i == 9) begin car_parked = 1'b1; vehicle_no = 32'd3002; end
      if (i == 10) car_parked = 1'b0;
    end
    chk("cc_first_at", e_at, 10);
    chk("cc_first_ack", ea, 1);
    chk("cc_first_slot", es, 0);
    chk("cc_first_occ", eo, 8);
    chk("cc_second_at", e2_at, 20);
    chk("cc_second_nack", e2nack, 1);
    chk("cc_second_dup", e2dup, 1);
    chk("cc_second_slot", e2s, 0);
    chk("cc_no_overrun", o_at, -1);

    // Reset in the middle of an entry scan.
    @(negedge clk);
    car_parked = 1'b1; vehicle_no = 32'd8888;
    @(negedge clk);
    car_parked = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (entry_ack | entry_nack | exit_ack | exit_nack) any = 1'b1;
    end
    chk("mid_rst_no_resp", any, 0);
    chk("mid_rst_occ", occ_count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_slot", slot_id, 0);
    do_event(1'b1, 32'd1104, lat);
    chk("post_rst_exit_lat", lat, 10);
    chk("post_rst_exit_nack", c_xnack, 1);
    chk("post_rst_exit_ack", c_xack, 0);
    chk("post_rst_occ", c_occ, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
